// File: rtl/axilite_master_q_if.sv
// AXI4-Lite bus bundle shared by the queued master and the slave it drives.
interface axilite_master_q_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axilite_master_q.sv
// AXI4-Lite master: backend write/read commands are queued per direction and issued
// in order, one outstanding per direction, with registered AXI outputs.
//  state  | meaning
//  W_IDLE | write queue checked; head launched on AW and W together
//  W_XFER | AW and/or W still waiting for their ready
//  W_RESP | bready high, waiting for B
//  R_IDLE | read queue checked; head launched on AR
//  R_ADDR | arvalid high, waiting for arready
//  R_DATA | rready high, waiting for R
module axilite_master_q #(
    parameter  int ADDR_W = 12,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int STRB_W = DATA_W / 8,
    localparam int PW     = $clog2(DEPTH),
    localparam int LW     = PW + 1
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              bk_wvalid_i,
    output logic              bk_wready_o,
    input  logic [ADDR_W-1:0] bk_waddr_i,
    input  logic [DATA_W-1:0] bk_wdata_i,
    input  logic [STRB_W-1:0] bk_wstrb_i,
    output logic              bk_wdone_o,
    output logic [1:0]        bk_wresp_o,
    input  logic              bk_rvalid_i,
    output logic              bk_rready_o,
    input  logic [ADDR_W-1:0] bk_raddr_i,
    output logic              bk_rdone_o,
    output logic [DATA_W-1:0] bk_rdata_o,
    output logic [1:0]        bk_rresp_o,
    output logic [LW-1:0]     bk_wlevel_o,
    output logic [LW-1:0]     bk_rlevel_o,
    axilite_master_q_if.master axi
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wcmd_t;

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wst_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rst_t;

    // ---------------- command queues ----------------
    wcmd_t             wmem [DEPTH];
    logic [ADDR_W-1:0] rmem [DEPTH];
    logic [PW-1:0]     wwp_q, wrp_q, rwp_q, rrp_q;
    logic [LW-1:0]     wlvl_q, rlvl_q;
    logic              wpush, wpop, rpush, rpop;
    wcmd_t             whead;
    logic [ADDR_W-1:0] rhead;

    // Full is judged on the registered level only, so a same-cycle pop never frees a slot early.
    assign bk_wready_o = (wlvl_q != LW'(DEPTH));
    assign bk_rready_o = (rlvl_q != LW'(DEPTH));
    assign wpush       = bk_wvalid_i && bk_wready_o;
    assign rpush       = bk_rvalid_i && bk_rready_o;
    assign whead       = wmem[wrp_q];
    assign rhead       = rmem[rrp_q];
    assign bk_wlevel_o = wlvl_q;
    assign bk_rlevel_o = rlvl_q;

    always_ff @(posedge axi_aclk) begin
        if (wpush) wmem[wwp_q] <= '{addr: bk_waddr_i, data: bk_wdata_i, strb: bk_wstrb_i};
        if (rpush) rmem[rwp_q] <= bk_raddr_i;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wwp_q  <= '0;
            wrp_q  <= '0;
            wlvl_q <= '0;
            rwp_q  <= '0;
            rrp_q  <= '0;
            rlvl_q <= '0;
        end else begin
            if (wpush) wwp_q <= wwp_q + 1'b1;
            if (wpop)  wrp_q <= wrp_q + 1'b1;
            if (rpush) rwp_q <= rwp_q + 1'b1;
            if (rpop)  rrp_q <= rrp_q + 1'b1;
            wlvl_q <= wlvl_q + LW'(wpush) - LW'(wpop);
            rlvl_q <= rlvl_q + LW'(rpush) - LW'(rpop);
        end
    end

    // ---------------- write engine ----------------
    wst_t              wst_q, wst_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              wdone_q, wdone_d;
    logic [1:0]        wresp_q, wresp_d;
    logic              aw_ok, w_ok;

    assign aw_ok = !awvalid_q || axi.awready;
    assign w_ok  = !wvalid_q || axi.wready;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wst_q     <= W_IDLE;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bready_q  <= 1'b0;
            wdone_q   <= 1'b0;
            wresp_q   <= 2'b00;
        end else begin
            wst_q     <= wst_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bready_q  <= bready_d;
            wdone_q   <= wdone_d;
            wresp_q   <= wresp_d;
        end
    end

    always_comb begin
        wst_d = wst_q;
        unique case (wst_q)
            W_IDLE:  if (wlvl_q != '0) wst_d = W_XFER;
            W_XFER:  if (aw_ok && w_ok) wst_d = W_RESP;
            W_RESP:  if (axi.bvalid) wst_d = W_IDLE;
            default: wst_d = W_IDLE;
        endcase
    end

    always_comb begin
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        wvalid_d  = wvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bready_d  = bready_q;
        wdone_d   = 1'b0;
        wresp_d   = wresp_q;
        wpop      = 1'b0;
        unique case (wst_q)
            W_IDLE: begin
                if (wst_d == W_XFER) begin
                    awvalid_d = 1'b1;
                    awaddr_d  = whead.addr;
                    wvalid_d  = 1'b1;
                    wdata_d   = whead.data;
                    wstrb_d   = whead.strb;
                end
            end
            W_XFER: begin
                if (awvalid_q && axi.awready) begin
                    awvalid_d = 1'b0;
                    awaddr_d  = '0;
                end
                if (wvalid_q && axi.wready) begin
                    wvalid_d = 1'b0;
                    wdata_d  = '0;
                    wstrb_d  = '0;
                end
                if (wst_d == W_RESP) bready_d = 1'b1;
            end
            W_RESP: begin
                if (axi.bvalid) begin
                    bready_d = 1'b0;
                    wdone_d  = 1'b1;
                    wresp_d  = axi.bresp;
                    wpop     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- read engine ----------------
    rst_t              rd_st_q, rd_st_d;
    logic              arvalid_q, arvalid_d, rready_q, rready_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              rdone_q, rdone_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rd_st_q   <= R_IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            rdone_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            rd_st_q   <= rd_st_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            rready_q  <= rready_d;
            rdone_q   <= rdone_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        rd_st_d = rd_st_q;
        unique case (rd_st_q)
            R_IDLE:  if (rlvl_q != '0) rd_st_d = R_ADDR;
            R_ADDR:  if (axi.arready) rd_st_d = R_DATA;
            R_DATA:  if (axi.rvalid) rd_st_d = R_IDLE;
            default: rd_st_d = R_IDLE;
        endcase
    end

    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        rready_d  = rready_q;
        rdone_d   = 1'b0;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rpop      = 1'b0;
        unique case (rd_st_q)
            R_IDLE: begin
                if (rd_st_d == R_ADDR) begin
                    arvalid_d = 1'b1;
                    araddr_d  = rhead;
                end
            end
            R_ADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    araddr_d  = '0;
                    rready_d  = 1'b1;
                end
            end
            R_DATA: begin
                if (axi.rvalid) begin
                    rready_d = 1'b0;
                    rdone_d  = 1'b1;
                    rdata_d  = axi.rdata;
                    rresp_d  = axi.rresp;
                    rpop     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = araddr_q;
    assign axi.rready  = rready_q;
    assign bk_wdone_o  = wdone_q;
    assign bk_wresp_o  = wresp_q;
    assign bk_rdone_o  = rdone_q;
    assign bk_rdata_o  = rdata_q;
    assign bk_rresp_o  = rresp_q;
endmodule
